// File: rtl/key_event_fifo.sv
// rtl/key_event_fifo.sv - keycode press-event FIFO with optional typematic repeat
// Define KEY_REPEAT_EN to compile in the IDLE/DELAY/REPEAT repeat generator.
module key_event_fifo #(
  parameter int DEPTH        = 8,
  parameter int REPEAT_DELAY = 500000,
  parameter int REPEAT_RATE  = 100000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             key_data,
  input  logic                   rd_en,
  input  logic                   clr_ovf,
  output logic [7:0]             rd_data,
  output logic                   rd_valid,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   irq
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_param
    $error("key_event_fifo: DEPTH must be a power of two >= 2 and repeat timings >= 1");
  end

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [7:0]    prev_key;
  logic          press;
  logic          evt;
  logic          do_rd;
  logic          do_wr;
  logic          drop;

  // A change to a nonzero code is a press; releasing to 0 is silent.
  assign press = (key_data != prev_key) && (key_data != 8'd0);

`ifdef KEY_REPEAT_EN
  localparam int CMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rep_state_t;

  rep_state_t    state;
  rep_state_t    state_nxt;
  logic [CW-1:0] rep_cnt;
  logic [CW-1:0] rep_cnt_nxt;
  logic          rep_evt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      rep_cnt <= '0;
    end else begin
      state   <= state_nxt;
      rep_cnt <= rep_cnt_nxt;
    end
  end

  // Without a press and with a nonzero code, key_data equals prev_key: the key is held.
  always_comb begin
    state_nxt   = state;
    rep_cnt_nxt = rep_cnt;
    rep_evt     = 1'b0;
    if (press) begin
      state_nxt   = DELAY;
      rep_cnt_nxt = '0;
    end else if (key_data == 8'd0) begin
      state_nxt   = IDLE;
      rep_cnt_nxt = '0;
    end else begin
      case (state)
        DELAY: begin
          if (rep_cnt == CW'(REPEAT_DELAY - 1)) begin
            rep_evt     = 1'b1;
            state_nxt   = REPEAT;
            rep_cnt_nxt = '0;
          end else begin
            rep_cnt_nxt = rep_cnt + 1'b1;
          end
        end
        REPEAT: begin
          if (rep_cnt == CW'(REPEAT_RATE - 1)) begin
            rep_evt     = 1'b1;
            rep_cnt_nxt = '0;
          end else begin
            rep_cnt_nxt = rep_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign evt = press | rep_evt;
`else
  assign evt = press;
`endif

  assign empty = (count == '0);
  assign full  = (count == CNTW'(DEPTH));
  assign irq   = !empty;

  // A pop frees a slot in the same cycle, so a write while full is accepted alongside it.
  assign do_rd = rd_en && !empty;
  assign do_wr = evt && (!full || do_rd);
  assign drop  = evt && full && !do_rd;

  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr] <= key_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_key <= 8'd0;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      rd_data  <= 8'd0;
      rd_valid <= 1'b0;
      overflow <= 1'b0;
    end else begin
      prev_key <= key_data;
      rd_valid <= do_rd;
      if (do_wr) wptr <= wptr + 1'b1;
      if (do_rd) begin
        rptr    <= rptr + 1'b1;
        rd_data <= mem[rptr];
      end
      if (do_wr && !do_rd)      count <= count + 1'b1;
      else if (!do_wr && do_rd) count <= count - 1'b1;
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_key_event_fifo.sv
// tb/tb_key_event_fifo.sv - self-checking bench for key_event_fifo against a queue model
// Repeat expectations follow KEY_REPEAT_EN when the bench is built with it.
module tb_key_event_fifo;

  localparam int DEPTH = 8;
  localparam int RD    = 20;
  localparam int RR    = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] key_data = 8'd0;
  logic       rd_en = 1'b0;
  logic       clr_ovf = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       empty;
  logic       full;
  logic [3:0] count;
  logic       overflow;
  logic       irq;

  int checks = 0;
  int errors = 0;

  logic [7:0] q[$];
  logic       m_ovf;
  logic [7:0] m_prev;
  logic [7:0] m_rd;
  logic       m_valid;

  key_event_fifo #(.DEPTH(DEPTH), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut (
    .clk(clk), .rst(rst), .key_data(key_data), .rd_en(rd_en), .clr_ovf(clr_ovf),
    .rd_data(rd_data), .rd_valid(rd_valid), .empty(empty), .full(full),
    .count(count), .overflow(overflow), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    q.delete();
    m_ovf = 1'b0;
    m_prev = 8'd0;
    m_rd = 8'd0;
    m_valid = 1'b0;
  endtask

  // Drive one cycle of inputs, advance the model, then sample 1 time unit after the edge.
  task automatic step(input logic [7:0] k, input logic r, input logic c);
    bit press, pop, drop;
    int sz;
    key_data = k;
    rd_en = r;
    clr_ovf = c;
    sz = q.size();
    press = (k != m_prev) && (k != 8'd0);
    pop = r && (sz > 0);
    m_valid = pop;
    if (pop) m_rd = q.pop_front();
    drop = press && (sz == DEPTH) && !pop;
    if (press && !drop) q.push_back(k);
    if (drop) m_ovf = 1'b1;
    else if (c) m_ovf = 1'b0;
    m_prev = k;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    key_data = 8'd0;
    rd_en = 1'b0;
    clr_ovf = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (count !== 4'd0 || empty !== 1'b1 || full !== 1'b0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: count=%0d empty=%b full=%b irq=%b, required 0/1/0/0", count, empty, full, irq);
    end
    checks++;
    if (overflow !== 1'b0 || rd_valid !== 1'b0 || rd_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_rd: ovf=%b rd_valid=%b rd_data=%h, required 0/0/00", overflow, rd_valid, rd_data);
    end
  endtask

  task automatic test_basic();
    step(8'h00, 0, 0);
    step(8'h04, 0, 0);
    checks++;
    if (count !== 4'd1 || irq !== 1'b1) begin
      errors++;
      $display("FAIL basic_latency: count=%0d irq=%b, required 1/1", count, irq);
    end
    step(8'h04, 0, 0);
    step(8'h04, 0, 0);
    step(8'h00, 0, 0);
    step(8'h05, 0, 0);
    step(8'h00, 0, 0);
    checks++;
    if (count !== 4'd2) begin
      errors++;
      $display("FAIL basic_count: count=%0d, required 2", count);
    end
    step(8'h00, 1, 0);
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 8'h04) begin
      errors++;
      $display("FAIL basic_pop1: rd_valid=%b rd_data=%h, required 1/04", rd_valid, rd_data);
    end
    step(8'h00, 0, 0);
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== 8'h04) begin
      errors++;
      $display("FAIL basic_pulse: rd_valid=%b rd_data=%h, required 0/04", rd_valid, rd_data);
    end
    step(8'h00, 1, 0);
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 8'h05) begin
      errors++;
      $display("FAIL basic_pop2: rd_valid=%b rd_data=%h, required 1/05", rd_valid, rd_data);
    end
    step(8'h00, 0, 0);
    checks++;
    if (empty !== 1'b1 || irq !== 1'b0 || rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_empty: empty=%b irq=%b rd_valid=%b, required 1/0/0", empty, irq, rd_valid);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 9; i++) begin
      step(8'(8'h10 + i), 0, 0);
      if (i == 7) begin
        checks++;
        if (full !== 1'b1 || overflow !== 1'b0) begin
          errors++;
          $display("FAIL ovf_full8: full=%b ovf=%b, required 1/0", full, overflow);
        end
      end
    end
    checks++;
    if (overflow !== 1'b1 || count !== 4'd8) begin
      errors++;
      $display("FAIL ovf_drop9: ovf=%b count=%0d, required 1/8", overflow, count);
    end
    step(8'h40, 0, 1);
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_drop_wins: ovf=%b, required 1", overflow);
    end
    step(8'h00, 0, 0);
    for (int i = 0; i < 8; i++) begin
      step(8'h00, 1, 0);
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== 8'(8'h10 + i)) begin
        errors++;
        $display("FAIL ovf_pop%0d: rd_valid=%b rd_data=%h, required 1/%h", i, rd_valid, rd_data, 8'(8'h10 + i));
      end
    end
    step(8'h00, 0, 1);
    checks++;
    if (overflow !== 1'b0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL ovf_clear: ovf=%b empty=%b, required 0/1", overflow, empty);
    end
  endtask

  task automatic test_full_rw();
    logic [7:0] exp_seq [8];
    for (int i = 0; i < 8; i++) step(8'(8'h20 + i), 0, 0);
    step(8'h30, 1, 0);
    checks++;
    if (count !== 4'd8 || rd_data !== 8'h20 || overflow !== 1'b0 || rd_valid !== 1'b1) begin
      errors++;
      $display("FAIL full_rw: count=%0d rd_data=%h ovf=%b rd_valid=%b, required 8/20/0/1", count, rd_data, overflow, rd_valid);
    end
    for (int i = 0; i < 7; i++) exp_seq[i] = 8'(8'h21 + i);
    exp_seq[7] = 8'h30;
    for (int i = 0; i < 8; i++) begin
      step(8'h00, 1, 0);
      checks++;
      if (rd_data !== exp_seq[i]) begin
        errors++;
        $display("FAIL full_rw_order%0d: rd_data=%h, required %h", i, rd_data, exp_seq[i]);
      end
    end
  endtask

  task automatic test_empty_and_reset();
    step(8'h00, 1, 0);
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== 8'h30) begin
      errors++;
      $display("FAIL empty_read: rd_valid=%b rd_data=%h, required 0/30", rd_valid, rd_data);
    end
    step(8'h61, 1, 0);
    checks++;
    if (rd_valid !== 1'b0 || count !== 4'd1) begin
      errors++;
      $display("FAIL empty_wr_rd: rd_valid=%b count=%0d, required 0/1", rd_valid, count);
    end
    step(8'h52, 0, 0);
    step(8'h53, 0, 0);
    step(8'h00, 0, 0);
    rst = 1'b1;
    #1;
    checks++;
    if (count !== 4'd0 || empty !== 1'b1 || irq !== 1'b0 || rd_data !== 8'h00) begin
      errors++;
      $display("FAIL async_reset: count=%0d empty=%b irq=%b rd_data=%h, required 0/1/0/00", count, empty, irq, rd_data);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    step(8'h60, 0, 0);
    step(8'h00, 1, 0);
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 8'h60 || empty !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_pop: rd_valid=%b rd_data=%h empty=%b, required 1/60/1", rd_valid, rd_data, empty);
    end
  endtask

  task automatic test_random();
    logic [7:0] cur, nk;
    int hold, rd_pct;
    cur = 8'h00;
    hold = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      rd_pct = ((cyc / 100) % 2 == 0) ? 15 : 55;
      if (hold == 0) begin
        do begin
          if ($urandom_range(0, 3) == 0) nk = 8'h00;
          else nk = 8'($urandom_range(1, 255));
        end while (nk == cur);
        cur = nk;
        hold = $urandom_range(1, 6);
      end
      hold--;
      step(cur, ($urandom_range(0, 99) < rd_pct), ($urandom_range(0, 9) == 0));
      checks++;
      if (count !== 4'(q.size()) || empty !== (q.size() == 0) || full !== (q.size() == DEPTH) || irq !== (q.size() != 0)) begin
        errors++;
        $display("FAIL rand_occ cyc%0d: count=%0d empty=%b full=%b irq=%b, required count %0d", cyc, count, empty, full, irq, q.size());
      end
      checks++;
      if (rd_valid !== m_valid || rd_data !== m_rd || overflow !== m_ovf) begin
        errors++;
        $display("FAIL rand_rd cyc%0d: rd_valid=%b rd_data=%h ovf=%b, required %b/%h/%b", cyc, rd_valid, rd_data, overflow, m_valid, m_rd, m_ovf);
      end
    end
  endtask

  task automatic test_repeat();
    int offs[$];
    int exp_n, total;
`ifdef KEY_REPEAT_EN
    offs = '{0, RD, RD + RR, RD + 2 * RR, RD + 3 * RR};
`else
    offs = '{0};
`endif
    do_reset();
    total = offs.size();
    for (int k = 0; k < 60; k++) begin
      key_data = (k < 40) ? 8'h1E : 8'h00;
      @(posedge clk);
      #1;
      exp_n = 0;
      foreach (offs[j]) if (offs[j] <= k) exp_n++;
      checks++;
      if (count !== 4'(exp_n)) begin
        errors++;
        $display("FAIL repeat_cnt k%0d: count=%0d, required %0d", k, count, exp_n);
      end
    end
    for (int i = 0; i < total; i++) begin
      rd_en = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== 8'h1E) begin
        errors++;
        $display("FAIL repeat_pop%0d: rd_valid=%b rd_data=%h, required 1/1e", i, rd_valid, rd_data);
      end
    end
    rd_en = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("FAIL repeat_drain: empty=%b, required 1", empty);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_overflow();
    test_full_rw();
    test_empty_and_reset();
    test_random();
    test_repeat();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_event_fifo.md
KEY_EVENT_FIFO -- requirements
Module: key_event_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entries; power of two, minimum 2.
REQ-002 SHALL have parameter REPEAT_DELAY, default 500000, cycles a key is held before the first repeat event.
REQ-003 SHALL have parameter REPEAT_RATE, default 100000, cycles between subsequent repeat events.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 key_data  input  8  registered keycode from the USB stage; 0 means no key pressed.
REQ-007 rd_en  input  1  pop request from the I2C register side.
REQ-008 clr_ovf  input  1  clears the overflow flag.
REQ-009 rd_data  output  8  popped keycode.
REQ-010 rd_valid  output  1  rd_data holds a fresh pop; one-cycle pulse.
REQ-011 empty  output  1  FIFO holds 0 entries.
REQ-012 full  output  1  FIFO holds DEPTH entries.
REQ-013 count  output  log2(DEPTH)+1  current occupancy.
REQ-014 overflow  output  1  sticky flag; an event was dropped.
REQ-015 irq  output  1  equals !empty; level interrupt to the host.

Function
REQ-016 SHALL hold prev_key, an 8-bit register updated with key_data on every clock.
REQ-017 A press event SHALL occur in a cycle where key_data != prev_key and key_data != 0; a release to 0 SHALL NOT generate an event.
REQ-018 Each event SHALL write key_data into the FIFO at the same clock edge; count, empty, full and irq SHALL reflect the write after that edge (1-cycle latency).
REQ-019 Write and read pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH.
REQ-020 An event while full with no pop in the same cycle SHALL be dropped, SHALL set overflow, and SHALL leave the contents unchanged.
REQ-021 An event and a pop in the same cycle while full SHALL both be accepted; count SHALL stay DEPTH.
REQ-022 An event and a pop in the same cycle while empty SHALL be a write only; rd_valid SHALL stay 0.
REQ-023 rd_en with !empty SHALL load rd_data from the oldest entry and assert rd_valid on the next cycle; a FIFO-order mismatch is a failure.
REQ-024 rd_en while empty SHALL be ignored; rd_valid SHALL be 0 and rd_data SHALL hold its value.
REQ-025 rd_data SHALL hold its last value until the next successful pop.
REQ-026 clr_ovf SHALL clear overflow at the next edge; a drop in the same cycle SHALL win, leaving overflow = 1.

Reset
REQ-027 rst SHALL immediately force rd_data=0, rd_valid=0, count=0, empty=1, full=0, overflow=0, irq=0, prev_key=0, pointers=0, repeat FSM=IDLE, repeat counter=0.
REQ-028 FIFO storage SHALL NOT require reset; entries become visible only after a write.
REQ-029 Reset asserted mid-operation SHALL discard all queued events; the first post-reset event SHALL be read from entry 0.

Configuration
REQ-030 Macro KEY_REPEAT_EN SHALL compile in typematic repeat; without it the FSM and counter SHALL be absent and only press events are queued.
REQ-031 With KEY_REPEAT_EN, the FSM states SHALL be IDLE, DELAY and REPEAT; a counter SHALL count cycles.
REQ-032 Any press event SHALL move the FSM to DELAY and clear the counter.
REQ-033 In DELAY, after key_data has equalled prev_key (nonzero) for REPEAT_DELAY cycles, the FSM SHALL inject a repeat event, go to REPEAT and clear the counter.
REQ-034 In REPEAT, it SHALL inject a repeat event every REPEAT_RATE cycles.
REQ-035 key_data = 0 in DELAY or REPEAT SHALL return the FSM to IDLE; a new nonzero code SHALL restart DELAY via REQ-032.
REQ-036 Repeat events SHALL obey the full and overflow rules of REQ-020 and REQ-021.

Verification (DEPTH=8, REPEAT_DELAY=20, REPEAT_RATE=5)
REQ-037 key_data 0x00 -> 0x04 (hold 3 cycles) -> 0x00 -> 0x05 -> expect count=2; two pops give 0x04 then 0x05, each with a one-cycle rd_valid; then empty=1 and irq=0.
REQ-038 9 distinct codes 0x10..0x18 with no reads -> expect full=1 after the 8th and overflow=1 after the 9th; pops give 0x10..0x17; clr_ovf -> overflow=0.
REQ-039 FIFO full, new code and rd_en in the same cycle -> expect count stays 8, pop returns the oldest entry, new code is last, overflow=0.
REQ-040 rd_en while empty -> expect rd_valid=0 and rd_data unchanged; rst asserted with 3 entries queued -> expect count=0 and empty=1 immediately.
REQ-041 KEY_REPEAT_EN: hold 0x1E for 40 cycles -> expect events at press, press+20, +25, +30, +35 (5 total); release -> no further events.
REQ-042 KEY_REPEAT_EN undefined: same 40-cycle hold -> expect exactly 1 event.
